// File: rtl/nexys_starship_pkg.sv
// Shared encodings for the starship threat scheduler: FSM states, LFSR taps, sizing helpers.
package nexys_starship_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_RUN  = 3'b010,
        S_LOST = 3'b100
    } state_t;

    // Fibonacci feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7,5,4,3)
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam int         NUM_TERM_DEF = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nexys_starship_tick_gen.sv
// Game tick prescaler: tick is high for one cycle every TICK_DIV cycles while en is high.
// Counter is held at zero whenever en is low so every game starts on a fresh tick phase.
module nexys_starship_tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nexys_starship_threat_scheduler.sv
// Spawns, ages and clears threats on NUM_TERM terminals during PLAY; flags game_over on expiry.
// Clears and spawns land one cycle after the request; LOST freezes every output until play_en drops.
module nexys_starship_threat_scheduler
    import nexys_starship_pkg::*;
#(
    parameter int         NUM_TERM    = NUM_TERM_DEF,
    parameter int         TICK_DIV    = 1000000,
    parameter int         SPAWN_INIT  = 200,
    parameter int         SPAWN_MIN   = 50,
    parameter int         SPAWN_STEP  = 10,
    parameter int         THREAT_LIFE = 500,
    parameter int         LEVEL_KILLS = 8,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                play_en,
    input  logic [NUM_TERM-1:0] clear_req,
    output logic [NUM_TERM-1:0] threat_active,
    output logic [NUM_TERM-1:0] threat_urgent,
    output logic                spawn_pulse,
    output logic                game_over,
    output logic [15:0]         kill_count,
    output logic [3:0]          level
);

    localparam int IDX_W = idx_width(NUM_TERM);
    localparam int LW    = $clog2(THREAT_LIFE + 1);

    state_t              state;
    logic [7:0]          lfsr;
    logic [15:0]         spawn_cnt;
    logic                tick;
    logic                run;
    logic                wipe;
    logic [NUM_TERM-1:0] active;
    logic [NUM_TERM-1:0] clr_vld;
    logic [NUM_TERM-1:0] expire;
    logic [NUM_TERM-1:0] spawn_sel;
    logic                found;
    logic                expire_any;
    logic                do_spawn;
    logic [IDX_W-1:0]    start;
    logic [IDX_W-1:0]    pj;
    logic [15:0]         dec;
    logic [15:0]         interval;
    logic [16:0]         kill_sum;
    logic [15:0]         kill_new;
    logic                crossed;

    nexys_starship_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (run),
        .tick  (tick)
    );

    assign run        = (state == S_RUN);
    assign wipe       = (state == S_IDLE) || !play_en;
    assign expire_any = |expire;
    assign start      = IDX_W'(lfsr % 8'(NUM_TERM));

    // Probe from the random start and take the first idle terminal; a terminal
    // being cleared this cycle still reads as busy because active has not dropped yet.
    always_comb begin
        spawn_sel = '0;
        found     = 1'b0;
        pj        = '0;
        for (int k = 0; k < NUM_TERM; k++) begin
            pj = IDX_W'((int'(start) + k) % NUM_TERM);
            if (!found && !active[pj]) begin
                spawn_sel[pj] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign do_spawn = run && tick && (spawn_cnt == 16'd1) && found && !expire_any;

    // Clamp before subtracting so a high level never wraps the interval.
    assign dec      = 16'(level) * 16'(SPAWN_STEP);
    assign interval = ((dec + 16'(SPAWN_MIN)) >= 16'(SPAWN_INIT)) ? 16'(SPAWN_MIN)
                                                                : 16'(SPAWN_INIT) - dec;

    assign kill_sum = {1'b0, kill_count} + 17'($countones(clr_vld));
    assign kill_new = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    assign crossed  = (kill_new / 16'(LEVEL_KILLS)) != (kill_count / 16'(LEVEL_KILLS));

    for (genvar i = 0; i < NUM_TERM; i++) begin : g_term
        logic          a_q, a_n, u_q;
        logic [LW-1:0] l_q, l_n;

        assign clr_vld[i] = run && clear_req[i] && a_q;
        assign expire[i]  = run && tick && a_q && (l_q == LW'(1)) && !clear_req[i];

        always_comb begin
            a_n = a_q;
            l_n = l_q;
            if (wipe) begin
                a_n = 1'b0;
                l_n = '0;
            end else if (run && !expire_any) begin
                if (clr_vld[i]) begin
                    a_n = 1'b0;
                    l_n = '0;
                end else if (do_spawn && spawn_sel[i]) begin
                    a_n = 1'b1;
                    l_n = LW'(THREAT_LIFE);
                end else if (tick && a_q) begin
                    l_n = l_q - LW'(1);
                end
            end
        end

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                a_q <= 1'b0;
                l_q <= '0;
                u_q <= 1'b0;
            end else begin
                a_q <= a_n;
                l_q <= l_n;
                u_q <= a_n && (l_n <= LW'(THREAT_LIFE / 4));
            end
        end

        assign active[i]        = a_q;
        assign threat_active[i] = a_q;
        assign threat_urgent[i] = u_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            lfsr        <= LFSR_SEED;
            spawn_cnt   <= '0;
            spawn_pulse <= 1'b0;
            game_over   <= 1'b0;
            kill_count  <= '0;
            level       <= '0;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
            case (state)
                S_IDLE: begin
                    spawn_pulse <= 1'b0;
                    game_over   <= 1'b0;
                    kill_count  <= '0;
                    level       <= '0;
                    if (play_en) begin
                        state     <= S_RUN;
                        spawn_cnt <= 16'(SPAWN_INIT);
                    end
                end
                S_RUN: begin
                    if (!play_en) begin
                        state       <= S_IDLE;
                        spawn_pulse <= 1'b0;
                        kill_count  <= '0;
                        level       <= '0;
                    end else if (expire_any) begin
                        state       <= S_LOST;
                        game_over   <= 1'b1;
                        spawn_pulse <= 1'b0;
                    end else begin
                        spawn_pulse <= do_spawn;
                        if (tick) begin
                            spawn_cnt <= (spawn_cnt == 16'd1) ? interval : spawn_cnt - 16'd1;
                        end
                        kill_count <= kill_new;
                        if (crossed && (level != 4'hF)) begin
                            level <= level + 4'd1;
                        end
                    end
                end
                S_LOST: begin
                    spawn_pulse <= 1'b0;
                    if (!play_en) begin
                        state      <= S_IDLE;
                        game_over  <= 1'b0;
                        kill_count <= '0;
                        level      <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nexys_starship_threat_scheduler.sv
// Directed bench for the threat scheduler with a fast tick (TICK_DIV=2) and short lifetimes.
module tb_nexys_starship_threat_scheduler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        play_en;
    logic [3:0]  clear_req;
    logic [3:0]  threat_active;
    logic [3:0]  threat_urgent;
    logic        spawn_pulse;
    logic        game_over;
    logic [15:0] kill_count;
    logic [3:0]  level;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] lfsr_m, lfsr_prev;

    nexys_starship_threat_scheduler #(
        .NUM_TERM(4), .TICK_DIV(2), .SPAWN_INIT(4), .SPAWN_MIN(2), .SPAWN_STEP(1),
        .THREAT_LIFE(8), .LEVEL_KILLS(2), .LFSR_SEED(8'hA5)
    ) dut (
        .Clk(Clk), .Reset(Reset), .play_en(play_en), .clear_req(clear_req),
        .threat_active(threat_active), .threat_urgent(threat_urgent),
        .spawn_pulse(spawn_pulse), .game_over(game_over),
        .kill_count(kill_count), .level(level)
    );

    always #5 Clk = ~Clk;

    // Reference LFSR; lfsr_prev is the value that was live during the cycle before the last edge.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr_m    <= 8'hA5;
            lfsr_prev <= 8'hA5;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        end
    end

    function automatic logic [3:0] exp_spawn(input logic [3:0] act, input logic [7:0] lf);
        logic [3:0] r;
        int s;
        r = '0;
        s = int'(lf) % 4;
        for (int k = 0; k < 4; k++) begin
            if (r == 4'd0 && !act[(s + k) % 4]) r[(s + k) % 4] = 1'b1;
        end
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_spawn(output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (!spawn_pulse && cnt < 40);
        chk("spawn_seen", 32'(spawn_pulse), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        int         exp_int [7] = '{8, 8, 6, 6, 4, 4, 4};
        int         exp_lv  [7] = '{0, 1, 1, 2, 2, 3, 3};
        logic [3:0] b1, acc, bn, b8, b9;

        Reset = 1'b1; play_en = 1'b0; clear_req = '0;
        step(2);
        chk("rst_active", 32'(threat_active), 32'd0);
        chk("rst_urgent", 32'(threat_urgent), 32'd0);
        chk("rst_misc", {spawn_pulse, game_over, kill_count, level}, 32'd0);
        Reset = 1'b0;
        step(2);
        chk("idle_no_spawn", {spawn_pulse, threat_active}, 32'd0);

        // Game A: first spawn 8 clk after entry, then no clears until expiry
        play_en = 1'b1;
        step(8);
        chk("a_pre_spawn", {spawn_pulse, threat_active}, 32'd0);
        step(1);
        b1 = exp_spawn(4'd0, lfsr_prev);
        chk("a_spawn1_pulse", 32'(spawn_pulse), 32'd1);
        chk("a_spawn1_term", 32'(threat_active), 32'(b1));
        step(1);
        chk("a_pulse_width", 32'(spawn_pulse), 32'd0);
        step(6);
        chk("a_no_go_e16", 32'(game_over), 32'd0);
        step(1);
        acc = b1 | exp_spawn(b1, lfsr_prev);
        chk("a_spawn2", {spawn_pulse, threat_active}, {27'd0, 1'b1, acc});
        step(3);
        chk("a_urgent_e20", 32'(threat_urgent), 32'd0);
        step(1);
        chk("a_urgent_e21", 32'(threat_urgent), 32'(b1));
        step(3);
        chk("a_no_go_e24", 32'(game_over), 32'd0);
        step(1);
        chk("a_expiry", {game_over, spawn_pulse, threat_active}, {26'd0, 2'b10, acc});
        step(4);
        chk("a_frozen", {game_over, threat_active, threat_urgent}, {23'd0, 1'b1, acc, b1});
        play_en = 1'b0;
        step(1);
        chk("a_drop_play", {game_over, threat_active, threat_urgent}, 32'd0);

        // Game B: clear every threat, watch level and interval shrink
        play_en = 1'b1;
        wait_spawn(cnt);
        chk("b_first_latency", 32'(cnt), 32'd9);
        for (int n = 1; n <= 7; n++) begin
            bn = exp_spawn(4'd0, lfsr_prev);
            chk("b_spawn_term", 32'(threat_active), 32'(bn));
            step(2);
            clear_req = bn;
            step(1);
            clear_req = '0;
            chk("b_cleared", 32'(threat_active), 32'd0);
            chk("b_kills", 32'(kill_count), 32'(n));
            chk("b_level", 32'(level), 32'(exp_lv[n-1]));
            wait_spawn(cnt);
            chk("b_interval", 32'(3 + cnt), 32'(exp_int[n-1]));
        end

        // Fill all four terminals at the 2-tick interval
        b8 = exp_spawn(4'd0, lfsr_prev);
        acc = b8;
        chk("b_fill1", 32'(threat_active), 32'(acc));
        step(4);
        b9 = exp_spawn(acc, lfsr_prev);
        acc = acc | b9;
        chk("b_fill2", {spawn_pulse, threat_active}, {27'd0, 1'b1, acc});
        step(4);
        acc = acc | exp_spawn(acc, lfsr_prev);
        chk("b_fill3", {spawn_pulse, threat_active}, {27'd0, 1'b1, acc});
        step(4);
        chk("b_fill4", {spawn_pulse, threat_active}, {27'd0, 1'b1, 4'hF});
        step(3);
        chk("b_all_busy", {threat_active, threat_urgent}, {24'd0, 4'hF, b8});
        // Oldest threat is on its last tick: clear it on the same tick as a spawn attempt
        clear_req = b8;
        step(1);
        clear_req = '0;
        chk("b_full_no_spawn", 32'(spawn_pulse), 32'd0);
        chk("b_clear_beats_expiry", 32'(game_over), 32'd0);
        chk("b_after_clear", {threat_active, threat_urgent}, {24'd0, 4'hF & ~b8, b9});
        chk("b_kills_8", {kill_count, level}, {12'd0, 16'd8, 4'd4});

        // Reset mid-game with three threats live
        step(1);
        Reset = 1'b1;
        #1;
        chk("r_active", {threat_active, threat_urgent}, 32'd0);
        chk("r_misc", {spawn_pulse, game_over, kill_count, level}, 32'd0);
        step(1);
        Reset = 1'b0;
        wait_spawn(cnt);
        chk("c_first_latency", 32'(cnt), 32'd9);
        bn = exp_spawn(4'd0, lfsr_prev);
        chk("c_spawn_term", 32'(threat_active), 32'(bn));
        chk("c_fresh_score", {kill_count, level}, 32'd0);
        step(2);
        clear_req = bn;
        step(1);
        clear_req = '0;
        chk("c_kill1", {threat_active, kill_count, level}, {8'd0, 4'd0, 16'd1, 4'd0});
        play_en = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
